write_port_arbiter: RTL and testbench

Round-robin arbiter that shares the asynchronous FIFO's single write port among `NUM_REQ` requesters in the write clock domain. It grants bursts of up to `BURST_MAX` words, muxes the owner's data onto the FIFO write data bus, and drives `write_enable` into the write-pointer/full logic. It honours the registered `full` flag returned by that logic, so no write is ever issued while the FIFO is full.

---
 rtl/write_arb_pkg.sv | 27 ++
 rtl/rr_picker.sv | 33 +++
 rtl/write_port_arbiter.sv | 127 ++++++++++++
 tb/tb_write_port_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/write_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter and its round-robin
// picker: FSM state encoding, a constant clog2 helper and default parameters.
package write_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_BURST_MAX  = 4;

  // Ceiling log2 for sizing index and counter fields; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: finds the first set request bit
// searching upward, with wrap, from last_owner+1. Shared by write- and
// read-side arbiters.
module rr_picker
  import write_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  localparam int OWNER_W = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] request,
  input  logic [OWNER_W-1:0] last_owner,
  output logic               found,
  output logic [OWNER_W-1:0] next_owner
);

  // Scan offsets 1..NUM_REQ from last_owner; the lowest offset that hits wins.
  always_comb begin
    int idx;
    // NOTE: every combinational output gets a default before the search so
    // no path leaves it unassigned, which would infer a latch.
    found      = 1'b0;
    next_owner = '0;
    idx        = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_owner) + k) % NUM_REQ;
      if (!found && request[idx]) begin
        found      = 1'b1;
        next_owner = OWNER_W'(idx);
      end
    end
  end

endmodule

// File: rtl/write_port_arbiter.sv
// Round-robin arbiter sharing the async FIFO's single write port among
// NUM_REQ requesters. Grants bursts of up to BURST_MAX words and never
// writes while the registered full flag is high.
// Build option: define WRITE_ARB_RELEASE_ON_FULL_EN to make a full stall
// end the burst and send the stalled requester to the back of the rotation.
module write_port_arbiter
  import write_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BURST_MAX  = DEF_BURST_MAX,
  localparam int OWNER_W   = clog2(NUM_REQ),
  localparam int BEAT_W    = clog2(BURST_MAX) + 1
) (
  input  logic                          clock_write,
  input  logic                          write_reset_n,
  input  logic [NUM_REQ-1:0]            request,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] request_data,
  input  logic                          full,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          write_enable,
  output logic [DATA_WIDTH-1:0]         write_data,
  output logic [OWNER_W-1:0]            owner,
  output logic                          busy
);

  arb_state_e         state, state_next;
  logic [OWNER_W-1:0] owner_next;
  logic [OWNER_W-1:0] last_owner, last_owner_next;
  logic [BEAT_W-1:0]  beat, beat_next;

  logic               pick_found;
  logic [OWNER_W-1:0] pick_owner;
  logic               owner_req;
  logic               accept;
  logic               last_beat;
  logic               idle_ok;

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .request    (request),
    .last_owner (last_owner),
    .found      (pick_found),
    .next_owner (pick_owner)
  );

  assign owner_req = request[owner];
  assign busy      = (state == BURST);
  assign accept    = busy & owner_req & ~full;
  assign last_beat = (beat == BEAT_W'(BURST_MAX - 1));

`ifdef WRITE_ARB_RELEASE_ON_FULL_EN
  // Re-arbitration waits for space so a released owner cannot be re-picked
  // only to stall again.
  assign idle_ok = ~full;
`else
  assign idle_ok = 1'b1;
`endif

  // Write strobe, one-hot grant and data mux, all from current owner.
  always_comb begin
    grant = '0;
    if (accept) grant[owner] = 1'b1;
  end

  assign write_enable = accept;
  assign write_data   = request_data[owner*DATA_WIDTH +: DATA_WIDTH];

  // Next-state logic: arbitration in IDLE, beat counting and exit in BURST.
  always_comb begin
    state_next      = state;
    owner_next      = owner;
    last_owner_next = last_owner;
    beat_next       = beat;
    case (state)
      IDLE: begin
        if (pick_found && idle_ok) begin
          state_next = BURST;
          owner_next = pick_owner;
          beat_next  = '0;
        end
      end
      BURST: begin
        if (accept) begin
          if (last_beat) begin
            state_next      = IDLE;
            last_owner_next = owner;
            beat_next       = '0;
          end else begin
            beat_next = beat + 1'b1;
          end
        end else if (!owner_req) begin
          state_next      = IDLE;
          last_owner_next = owner;
          beat_next       = '0;
        end else begin
`ifdef WRITE_ARB_RELEASE_ON_FULL_EN
          // Full stall gives up the port; owner rejoins at the back.
          state_next      = IDLE;
          last_owner_next = owner;
          beat_next       = '0;
`endif
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, owner, rotation pointer and beat counter registers.
  always_ff @(posedge clock_write or negedge write_reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!write_reset_n) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= OWNER_W'(NUM_REQ - 1);
      beat       <= '0;
    end else begin
      state      <= state_next;
      owner      <= owner_next;
      last_owner <= last_owner_next;
      beat       <= beat_next;
    end
  end

endmodule

// File: tb/tb_write_port_arbiter.sv
// Self-checking bench for write_port_arbiter (4 requesters, 8-bit data,
// bursts of 4). Table-driven cycle vectors plus hand-written sequences for
// asynchronous reset and a 128-entry FIFO full model.
module tb_write_port_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;

  logic           clk;
  logic           rst_n;
  logic [NR-1:0]  request;
  logic [NR*DW-1:0] request_data;
  logic           full;
  logic           full_drv;
  logic [NR-1:0]  grant;
  logic           write_enable;
  logic [DW-1:0]  write_data;
  logic [1:0]     owner;
  logic           busy;

  // FIFO occupancy model for the integrated phase.
  logic           fifo_mode;
  int             fifo_count;
  logic           fifo_full;

  int n_checks = 0;
  int n_fail   = 0;

  write_port_arbiter #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .BURST_MAX  (4)
  ) dut (
    .clock_write   (clk),
    .write_reset_n (rst_n),
    .request       (request),
    .request_data  (request_data),
    .full          (full),
    .grant         (grant),
    .write_enable  (write_enable),
    .write_data    (write_data),
    .owner         (owner),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign fifo_full = (fifo_count == 128);
  assign full      = fifo_mode ? fifo_full : full_drv;

  // Write pointer model: full updates at the same edge the word is written.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) fifo_count <= 0;
    else if (fifo_mode && write_enable) fifo_count <= fifo_count + 1;
  end

  typedef struct {
    logic       rst_before;
    logic [3:0] req;
    logic       full;
    logic [3:0] grant;
    logic       busy;
    logic [1:0] owner;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic rb, input logic [3:0] rq, input logic f,
                     input logic [3:0] g, input logic b, input logic [1:0] o, input int reps);
    vec_t v;
    v.rst_before = rb; v.req = rq; v.full = f; v.grant = g; v.busy = b; v.owner = o;
    for (int r = 0; r < reps; r++) begin
      vecs.push_back(v);
      v.rst_before = 1'b0;
    end
  endtask

  task automatic set_data(input int k);
    for (int i = 0; i < NR; i++) request_data[i*DW +: DW] = {4'(i), 4'(k)};
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    request  = '0;
    full_drv = 1'b0;
    #2;
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_we", 32'(write_enable), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_owner", 32'(owner), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int k;
    rst_n = 1'b0; request = '0; full_drv = 1'b0; fifo_mode = 1'b0;
    set_data(0);
    #12;
    check("reset_grant", 32'(grant), 32'h0);
    check("reset_we", 32'(write_enable), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_owner", 32'(owner), 32'h0);
    check("reset_wdata", 32'(write_data), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Seq 1: requester 0 alone: idle, 4 grants, idle, 4 grants.
    add(0, 4'b0001, 0, 4'b0000, 0, 0, 1);
    add(0, 4'b0001, 0, 4'b0001, 1, 0, 4);
    add(0, 4'b0001, 0, 4'b0000, 0, 0, 1);
    add(0, 4'b0001, 0, 4'b0001, 1, 0, 4);
    add(0, 4'b0000, 0, 4'b0000, 0, 0, 1);
    // Seq 2: all request after reset: rotation 0,1,2,3,0.
    add(1, 4'b1111, 0, 4'b0000, 0, 0, 1);
    add(0, 4'b1111, 0, 4'b0001, 1, 0, 4);
    add(0, 4'b1111, 0, 4'b0000, 0, 0, 1);
    add(0, 4'b1111, 0, 4'b0010, 1, 1, 4);
    add(0, 4'b1111, 0, 4'b0000, 0, 1, 1);
    add(0, 4'b1111, 0, 4'b0100, 1, 2, 4);
    add(0, 4'b1111, 0, 4'b0000, 0, 2, 1);
    add(0, 4'b1111, 0, 4'b1000, 1, 3, 4);
    add(0, 4'b1111, 0, 4'b0000, 0, 3, 1);
    add(0, 4'b1111, 0, 4'b0001, 1, 0, 4);
    add(0, 4'b0000, 0, 4'b0000, 0, 0, 1);
    // Seq 3: requester 2 bursting, full for 3 cycles after 2 words;
    // requester 3 also pending.
    add(0, 4'b1100, 0, 4'b0000, 0, 0, 1);
    add(0, 4'b1100, 0, 4'b0100, 1, 2, 2);
`ifdef WRITE_ARB_RELEASE_ON_FULL_EN
    add(0, 4'b1100, 1, 4'b0000, 1, 2, 1);
    add(0, 4'b1100, 1, 4'b0000, 0, 2, 2);
    add(0, 4'b1100, 0, 4'b0000, 0, 2, 1);
    add(0, 4'b1100, 0, 4'b1000, 1, 3, 1);
    add(0, 4'b0000, 0, 4'b0000, 1, 3, 1);
    add(0, 4'b0000, 0, 4'b0000, 0, 3, 1);
`else
    add(0, 4'b1100, 1, 4'b0000, 1, 2, 3);
    add(0, 4'b1100, 0, 4'b0100, 1, 2, 2);
    add(0, 4'b1100, 0, 4'b0000, 0, 2, 1);
    add(0, 4'b1100, 0, 4'b1000, 1, 3, 1);
    add(0, 4'b0000, 0, 4'b0000, 1, 3, 1);
    add(0, 4'b0000, 0, 4'b0000, 0, 3, 1);
`endif
    // Seq 4: requester 1 drops after one word, requester 2 pending.
    add(0, 4'b0110, 0, 4'b0000, 0, 3, 1);
    add(0, 4'b0110, 0, 4'b0010, 1, 1, 1);
    add(0, 4'b0100, 0, 4'b0000, 1, 1, 1);
    add(0, 4'b0100, 0, 4'b0000, 0, 1, 1);
    add(0, 4'b0100, 0, 4'b0100, 1, 2, 1);
    add(0, 4'b0000, 0, 4'b0000, 1, 2, 1);
    add(0, 4'b0000, 0, 4'b0000, 0, 2, 1);

    for (int n = 0; n < vecs.size(); n++) begin
      if (vecs[n].rst_before) do_reset();
      @(negedge clk);
      request  = vecs[n].req;
      full_drv = vecs[n].full;
      k = n % 16;
      set_data(k);
      #1;
      check($sformatf("v%0d_grant", n), 32'(grant), 32'(vecs[n].grant));
      check($sformatf("v%0d_we", n), 32'(write_enable), 32'(|vecs[n].grant));
      check($sformatf("v%0d_busy", n), 32'(busy), 32'(vecs[n].busy));
      check($sformatf("v%0d_owner", n), 32'(owner), 32'(vecs[n].owner));
      check($sformatf("v%0d_wdata", n), 32'(write_data), 32'({2'b00, vecs[n].owner, 4'(k)}));
    end

    // Reset mid-burst: outputs drop without a clock edge, then requester 0
    // has priority again.
    @(negedge clk);
    request = 4'b0010;
    #1 check("mid_idle_busy", 32'(busy), 32'h0);
    @(negedge clk);
    #1 check("mid_grant", 32'(grant), 32'b0010);
    #1 rst_n = 1'b0;
    #1;
    check("async_grant", 32'(grant), 32'h0);
    check("async_we", 32'(write_enable), 32'h0);
    check("async_busy", 32'(busy), 32'h0);
    check("async_owner", 32'(owner), 32'h0);
    @(negedge clk);
    request = 4'b1111;
    rst_n = 1'b1;
    #1 check("post_rst_idle", 32'(busy), 32'h0);
    @(negedge clk);
    #1;
    check("post_rst_grant", 32'(grant), 32'b0001);
    check("post_rst_owner", 32'(owner), 32'h0);

    // Integrated with a 128-entry FIFO, no reads.
    do_reset();
    begin
      int viol;
      viol = 0;
      fifo_mode = 1'b1;
      @(negedge clk);
      request = 4'b0001;
      for (int c = 0; c < 300; c++) begin
        @(negedge clk);
        #1;
        if (write_enable && full) viol++;
      end
      check("fifo_writes", 32'(fifo_count), 32'd128);
      check("fifo_we_while_full", 32'(viol), 32'd0);
      check("fifo_full_flag", 32'(full), 32'h1);
      check("fifo_we_final", 32'(write_enable), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
